// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the fifo_gen2 buffer.
package fifo_pkg;

  localparam int DEF_B        = 8;
  localparam int DEF_W        = 4;
  localparam int DEF_AE_LEVEL = 1;

  function automatic int cnt_w(input int w);
    return w + 1;
  endfunction

  function automatic int def_af_level(input int w);
    return (2 ** w) - 1;
  endfunction

endpackage

// File: rtl/fifo_regfile.sv
// DEPTH x B storage: synchronous write, asynchronous read.
module fifo_regfile
  import fifo_pkg::*;
#(
  parameter int B = DEF_B,
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         we,
  input  logic [W-1:0] w_addr,
  input  logic [B-1:0] w_data,
  input  logic [W-1:0] r_addr,
  output logic [B-1:0] r_data
);

  logic [B-1:0] mem [2**W];

  always_ff @(posedge clk) begin
    if (we) mem[w_addr] <= w_data;
  end

  assign r_data = mem[r_addr];

endmodule

// File: rtl/fifo_gen2.sv
// Single-clock FIFO with programmable thresholds,
// occupancy count, error pulses and selectable read mode.
module fifo_gen2
  import fifo_pkg::*;
#(
  parameter int B        = DEF_B,
  parameter int W        = DEF_W,
  parameter int AF_LEVEL = def_af_level(W),
  parameter int AE_LEVEL = DEF_AE_LEVEL,
  parameter int FWFT     = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr,
  input  logic [B-1:0] w_data,
  input  logic         rd,
  output logic [B-1:0] r_data,
  output logic         full,
  output logic         empty,
  output logic         almost_full,
  output logic         almost_empty,
  output logic [W:0]   count,
  output logic         overflow,
  output logic         underflow
);

  localparam int CW = cnt_w(W);
  localparam logic [CW-1:0] DEPTH_C = CW'(2 ** W);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  logic [W-1:0] w_ptr;
  logic [W-1:0] r_ptr;
  logic         wr_ok;
  logic         rd_ok;
  logic [B-1:0] rf_q;

  // A write into a full FIFO is fine when a pop frees the slot.
  assign rd_ok = rd && !empty;
  assign wr_ok = wr && (!full || rd);

  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  fifo_regfile #(
    .B(B),
    .W(W)
  ) u_rf (
    .clk   (clk),
    .we    (wr_ok && !reset),
    .w_addr(w_ptr),
    .w_data(w_data),
    .r_addr(r_ptr),
    .r_data(rf_q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      w_ptr     <= '0;
      r_ptr     <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) w_ptr <= w_ptr + 1'b1;
      if (rd_ok) r_ptr <= r_ptr + 1'b1;
      unique case (1'b1)
        (wr_ok && !rd_ok): count <= count + 1'b1;
        (rd_ok && !wr_ok): count <= count - 1'b1;
        default:           count <= count;
      endcase
      overflow  <= wr && full && !rd;
      underflow <= rd && empty;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign r_data = rf_q;
    end else begin : g_reg
      logic [B-1:0] r_q;
      always_ff @(posedge clk) begin
        if (reset)      r_q <= '0;
        else if (rd_ok) r_q <= rf_q;
      end
      assign r_data = r_q;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_gen2.sv
// Bench for fifo_gen2: FWFT and registered variants
// against a queue-based reference model.
module tb_fifo_gen2;

  logic       clk = 1'b0;
  logic       reset, wr, rd;
  logic [7:0] w_data;
  logic [7:0] rdata_f, rdata_r;
  logic       full_f, empty_f, af_f, ae_f, ovf_f, udf_f;
  logic       full_r, empty_r, af_r, ae_r, ovf_r, udf_r;
  logic [2:0] cnt_f, cnt_r;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] q[$];
  logic [7:0] m_rreg;
  bit         m_ovf, m_udf;

  always #5 clk = ~clk;

  fifo_gen2 #(.B(8), .W(2), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(1)) u_f (
    .clk(clk), .reset(reset), .wr(wr), .w_data(w_data), .rd(rd),
    .r_data(rdata_f), .full(full_f), .empty(empty_f),
    .almost_full(af_f), .almost_empty(ae_f), .count(cnt_f),
    .overflow(ovf_f), .underflow(udf_f)
  );

  fifo_gen2 #(.B(8), .W(2), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(0)) u_r (
    .clk(clk), .reset(reset), .wr(wr), .w_data(w_data), .rd(rd),
    .r_data(rdata_r), .full(full_r), .empty(empty_r),
    .almost_full(af_r), .almost_empty(ae_r), .count(cnt_r),
    .overflow(ovf_r), .underflow(udf_r)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_all();
    int n;
    n = q.size();
    chk("cnt_f", 32'(cnt_f), n);
    chk("cnt_r", 32'(cnt_r), n);
    chk("full_f", 32'(full_f), 32'(n == 4));
    chk("full_r", 32'(full_r), 32'(n == 4));
    chk("empty_f", 32'(empty_f), 32'(n == 0));
    chk("empty_r", 32'(empty_r), 32'(n == 0));
    chk("af_f", 32'(af_f), 32'(n >= 3));
    chk("ae_f", 32'(ae_f), 32'(n <= 1));
    chk("af_r", 32'(af_r), 32'(n >= 3));
    chk("ae_r", 32'(ae_r), 32'(n <= 1));
    chk("ovf_f", 32'(ovf_f), 32'(m_ovf));
    chk("udf_f", 32'(udf_f), 32'(m_udf));
    chk("ovf_r", 32'(ovf_r), 32'(m_ovf));
    chk("udf_r", 32'(udf_r), 32'(m_udf));
    chk("rdata_reg", 32'(rdata_r), 32'(m_rreg));
    if (n > 0) chk("rdata_fwft", 32'(rdata_f), 32'(q[0]));
  endtask

  task automatic step(input bit rs, input bit w, input bit r,
                      input logic [7:0] d);
    int  n;
    bit  pop, push;
    reset  = rs;
    wr     = w;
    rd     = r;
    w_data = d;
    @(posedge clk);
    n = q.size();
    if (rs) begin
      q.delete();
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
      m_rreg = 8'h00;
    end else begin
      pop   = r && (n > 0);
      push  = w && ((n < 4) || r);
      m_ovf = w && (n == 4) && !r;
      m_udf = r && (n == 0);
      if (pop) m_rreg = q.pop_front();
      if (push) q.push_back(d);
    end
    #1;
    chk_all();
  endtask

  initial begin
    reset = 1'b1; wr = 1'b0; rd = 1'b0; w_data = 8'h00;
    m_rreg = 8'h00; m_ovf = 1'b0; m_udf = 1'b0;

    step(1, 0, 0, 0);
    step(1, 1, 1, 8'hAA);

    // thresholds while filling
    step(0, 1, 0, 8'd10);
    chk("first_word", 32'(rdata_f), 32'd10);
    step(0, 1, 0, 8'd20);
    chk("ae_drop", 32'(ae_f), 32'd0);
    step(0, 1, 0, 8'd30);
    chk("af_rise", 32'(af_f), 32'd1);
    step(0, 1, 0, 8'd40);
    step(0, 1, 0, 8'd50);
    chk("ovf_pulse", 32'(ovf_f), 32'd1);
    step(0, 0, 0, 0);
    chk("ovf_clear", 32'(ovf_f), 32'd0);

    // full with rd && wr wraps pointers
    step(0, 1, 1, 8'd9);
    chk("full_rw_cnt", 32'(cnt_f), 32'd4);
    chk("reg_rdata", 32'(rdata_r), 32'd10);
    repeat (4) step(0, 0, 1, 0);
    chk("drain_last", 32'(rdata_r), 32'd9);
    step(0, 0, 1, 0);
    chk("udf_pulse", 32'(udf_f), 32'd1);
    chk("reg_hold", 32'(rdata_r), 32'd9);
    step(0, 1, 1, 8'd7);
    chk("empty_rw_cnt", 32'(cnt_f), 32'd1);
    chk("empty_rw_fwft", 32'(rdata_f), 32'd7);

    // reset mid-operation
    step(0, 1, 0, 8'd1);
    step(0, 1, 0, 8'd2);
    step(1, 1, 0, 8'd3);
    chk("rst_cnt", 32'(cnt_f), 32'd0);
    step(0, 1, 0, 8'h55);
    step(0, 0, 1, 0);
    chk("rst_first", 32'(rdata_r), 32'h55);

    for (int i = 0; i < 800; i++) begin
      int bias;
      bias = (i / 100) % 3;
      step(($urandom_range(0, 99) < 2),
           ($urandom_range(0, 9) < (bias == 0 ? 8 : (bias == 1 ? 3 : 5))),
           ($urandom_range(0, 9) < (bias == 0 ? 3 : (bias == 1 ? 8 : 5))),
           8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_gen2.md
# fifo_gen2

Second-generation synchronous FIFO: a parametrised single-clock buffer with programmable almost-full/almost-empty thresholds, an occupancy count, overflow/underflow error pulses, and a selectable read mode (first-word-fall-through or registered). It replaces the fixed first-generation `fifo` wherever a producer/consumer pair needs back-pressure before the hard full/empty limits, e.g. between UART/serial front-ends and downstream processing.

## Interface
- `B`, 8, data width in bits (≥1)
- `W`, 4, address width; depth `DEPTH = 2**W` (W ≥ 1)
- `AF_LEVEL`, `2**W-1`, almost_full asserted when count ≥ AF_LEVEL (1..DEPTH)
- `AE_LEVEL`, 1, almost_empty asserted when count ≤ AE_LEVEL (0..DEPTH-1)
- `FWFT`, 1, 1 = first-word-fall-through read, 0 = registered read
- `clk`  in  1  single clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `wr`  in  1  write request
- `w_data`  in  B  write data, sampled with `wr`
- `rd`  in  1  read request (pop)
- `r_data`  out  B  read data (see Operation)
- `full`  out  1  count == DEPTH
- `empty`  out  1  count == 0
- `almost_full`  out  1  count ≥ AF_LEVEL
- `almost_empty`  out  1  count ≤ AE_LEVEL
- `count`  out  W+1  current occupancy, 0..DEPTH
- `overflow`  out  1  one-cycle pulse: write rejected
- `underflow`  out  1  one-cycle pulse: read rejected

## Operation
- Accepted write: `wr && (!full || rd)`; word stored at w_ptr, w_ptr increments mod DEPTH.
- Accepted read: `rd && !empty`; r_ptr increments mod DEPTH.
- count: +1 on write-only, −1 on read-only, unchanged on both or neither; never exceeds DEPTH or goes below 0.
- Full with rd && wr: both accepted, count stays DEPTH, no overflow.
- Empty with rd && wr: write accepted, read rejected, underflow pulses, count becomes 1. No bypass of write data to r_data in the same cycle.
- wr while full and !rd: write dropped, memory/pointers unchanged, overflow = 1 next cycle.
- rd while empty: pointers unchanged, underflow = 1 next cycle.
- FWFT=1: r_data = mem[r_ptr] continuously; valid whenever !empty; `rd` consumes the presented word. Value while empty is don't-care.
- FWFT=0: r_data is a register loaded with mem[r_ptr] on an accepted read; holds its value otherwise (including on rejected reads).
- Pointers are W bits, wrap naturally; full/empty derive from count, not pointer compare.
- Flags (full, empty, almost_*) are combinational from registered count; overflow/underflow are registered.

## Timing
- Reset (sync, takes effect at the edge where reset=1): pointers 0, count 0, empty=1, full=0, almost_empty=1 (AE_LEVEL ≥ 0), almost_full=0, overflow=0, underflow=0, r_data register 0 (FWFT=0). Memory contents not cleared. Requests in reset cycles ignored, no error pulses.
- Reset mid-operation: all contents discarded; first post-reset write occupies slot 0.
- Write-to-empty deassertion: empty falls the cycle after the accepted write edge.
- FWFT=1 read latency: written word visible on r_data the cycle after the write; FWFT=0: r_data valid the cycle after the accepted rd edge.
- Flags and count update on the same edge as the pointers.

## Structure
- Shared package `fifo_pkg`: helper function for count width (W+1) and default threshold constants; no typedefs beyond these.
- One sub-module: `fifo_regfile` (DEPTH×B storage, synchronous write port, asynchronous read port addressed by r_ptr). Control, count, flags and optional r_data register live in `fifo_gen2`.

## Test plan
Config B=8, W=2 (DEPTH=4), AF_LEVEL=3, AE_LEVEL=1 unless noted.
- Reset then write 10,20,30 (FWFT=1) -> count 1,2,3; almost_empty drops at count 2; almost_full rises at count 3; r_data=10 from cycle after first write.
- Fill with 1,2,3,4, then wr=1 w_data=5 alone -> full=1, overflow pulses one cycle, count stays 4; reading 4 times returns 1,2,3,4, empty=1.
- Full, then rd && wr with 9 for one cycle -> count 4, no overflow; subsequent drain returns 2,3,4,9 (pointer wrap).
- Empty, rd=1 -> underflow pulses one cycle; rd && wr with 7 -> count 1, underflow pulses, next r_data=7 (FWFT=1).
- FWFT=0: write 10,20; rd one cycle -> r_data=10 one cycle later and holds until next accepted rd; rd on empty leaves r_data unchanged.
- Fill to 3, assert reset one cycle with wr=1 -> count 0, empty=1, no overflow; next write of 0x55 read back first.
